// File: rtl/zxuno_regbus_ctrl.sv
// ----------------------------------------------------------------------------
// zxuno_regbus_ctrl
//
// Decodes the two CPU I/O ports that give access to the ZX-Uno register
// file. Writing ADDR_PORT selects a register number. Accesses to DATA_PORT
// are passed to the register's owner through strobes: zxuno_regwr is a
// one-clock pulse and zxuno_regrd is a level. Reads of DATA_PORT return
// the bus of the highest-priority peripheral that enables its output.
//
// Ports
//   clk              system clock; every input is synchronous to it
//   rst_n            synchronous reset, active low
//   a                CPU address bus
//   iorq_n/rd_n/wr_n CPU strobes, active low
//   din              CPU write data
//   dout, oe_n       read data to the CPU; oe_n is low while dout drives the bus
//   zxuno_addr       currently selected register number
//   zxuno_regrd      high for the whole data-port read cycle
//   zxuno_regwr      one-clock pulse per data-port write
//   regaddr_changed  one-clock pulse per address-port write
//   periph_dout      four 8-bit peripheral read buses; source k is [8k+7:8k]
//   periph_oe_n      per-peripheral output enables, active low
// ----------------------------------------------------------------------------
module zxuno_regbus_ctrl #(
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe_n,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        regaddr_changed,
    input  logic [31:0] periph_dout,
    input  logic [3:0]  periph_oe_n
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_WR  = 3'd1,
        ADDR_RD  = 3'd2,
        DATA_WR  = 3'd3,
        DATA_RD  = 3'd4,
        WAIT_END = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic [7:0] addr_q, addr_d;
    logic       regrd_q, regrd_d;
    logic       regwr_q, regwr_d;
    logic       addr_chg_q, addr_chg_d;

    logic rd_only;
    logic wr_only;
    logic hit_addr;
    logic hit_data;

    // A strobe pair with both rd_n and wr_n low is treated as noise.
    assign rd_only  = !rd_n && wr_n;
    assign wr_only  = !wr_n && rd_n;
    assign hit_addr = (a == ADDR_PORT);
    assign hit_data = (a == DATA_PORT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        regwr_d    = 1'b0;
        addr_chg_d = 1'b0;
        // The armed flag ensures that a single CPU cycle is accepted only
        // once. It re-arms only after iorq_n has been seen high.
        armed_d    = armed_q | iorq_n;

        case (state_q)
            IDLE: begin
                if (armed_q && !iorq_n && (rd_only || wr_only)) begin
                    if (hit_addr) begin
                        armed_d = 1'b0;
                        if (wr_only) begin
                            state_d    = ADDR_WR;
                            addr_d     = din;
                            addr_chg_d = 1'b1;
                        end else begin
                            state_d = ADDR_RD;
                        end
                    end else if (hit_data) begin
                        armed_d = 1'b0;
                        if (wr_only) begin
                            state_d = DATA_WR;
                            regwr_d = 1'b1;
                        end else begin
                            state_d = DATA_RD;
                        end
                    end
                end
            end
            ADDR_WR, DATA_WR: state_d = WAIT_END;
            ADDR_RD, DATA_RD, WAIT_END: begin
                if (iorq_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The read strobe is registered so that it follows the state exactly.
        regrd_d = (state_d == DATA_RD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            addr_q     <= 8'h00;
            regrd_q    <= 1'b0;
            regwr_q    <= 1'b0;
            addr_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            regrd_q    <= regrd_d;
            regwr_q    <= regwr_d;
            addr_chg_q <= addr_chg_d;
        end
    end

    // The read mux is combinational so that a peripheral may change its
    // enable during a long read and still be seen on the next cycle.
    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (state_q == ADDR_RD) begin
            oe_n = 1'b0;
            dout = addr_q;
        end else if (state_q == DATA_RD) begin
            oe_n = 1'b0;
            if (!periph_oe_n[0]) begin
                dout = periph_dout[7:0];
            end else if (!periph_oe_n[1]) begin
                dout = periph_dout[15:8];
            end else if (!periph_oe_n[2]) begin
                dout = periph_dout[23:16];
            end else if (!periph_oe_n[3]) begin
                dout = periph_dout[31:24];
            end
        end
    end

    assign zxuno_addr      = addr_q;
    assign zxuno_regrd     = regrd_q;
    assign zxuno_regwr     = regwr_q;
    assign regaddr_changed = addr_chg_q;

endmodule
